// File: rtl/apb_irq_ack_ctrl.sv
// Consumer-side service sequencer for the APB interrupt arbiter: raises a host
// interrupt, waits for done or timeout, then pulses the acknowledge word back.
module apb_irq_ack_ctrl #(
   parameter int         TIMEOUT_CYC  = 6_000_000,
   parameter int         ACK_PULSE    = 4,
   parameter int         RELEASE_MAX  = 16,
   parameter logic [7:0] EN_MASK_INIT = 8'h07
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_irq_sel,
   input  logic        i_irq_en,
   input  logic        i_cfg_wr,
   input  logic [7:0]  i_cfg_en,
   input  logic        i_host_done,
   output logic        o_host_irq,
   output logic [2:0]  o_host_src,
   output logic [31:0] o_irq_ack,
   output logic        o_busy,
   output logic [15:0] o_svc_cnt,
   output logic [15:0] o_timeout_cnt,
   output logic        o_err
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int AW = $clog2(ACK_PULSE);
   localparam int RW = $clog2(RELEASE_MAX) + 1;

   typedef enum logic [1:0] {IDLE, WAIT_HOST, ACK, RELEASE} state_t;

   state_t        state_reg, state_next;
   logic [TW-1:0] tmr_reg;
   logic [AW-1:0] ack_cnt_reg;
   logic [RW-1:0] rel_cnt_reg;
   logic [7:0]    sel_q_reg;
   logic [7:0]    en_mask_reg;
   logic          ack_bit_reg;
   logic [7:0]    ack_src_reg;
   logic          host_irq_reg;
   logic [2:0]    host_src_reg;
   logic          busy_reg;
   logic [15:0]   svc_cnt_reg;
   logic [15:0]   timeout_cnt_reg;
   logic          err_reg;

   logic          sel_onehot;
   logic [2:0]    sel_idx;
   logic          accept, bad_sel, svc_inc, to_inc, rel_err;

   assign sel_onehot = (i_irq_sel != 8'd0) && ((i_irq_sel & (i_irq_sel - 8'd1)) == 8'd0);

   always_comb begin
      sel_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (i_irq_sel[i]) sel_idx = sel_idx | 3'(i);
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      bad_sel    = 1'b0;
      svc_inc    = 1'b0;
      to_inc     = 1'b0;
      rel_err    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_irq_en) begin
               if (sel_onehot) begin
                  accept     = 1'b1;
                  state_next = WAIT_HOST;
               end else begin
                  bad_sel = 1'b1;
               end
            end
         end
         WAIT_HOST: begin
            // Done wins over a coincident expiry.
            if (i_host_done) begin
               svc_inc    = 1'b1;
               state_next = ACK;
            end else if (tmr_reg == TW'(TIMEOUT_CYC - 1)) begin
               to_inc     = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            if (ack_cnt_reg == AW'(ACK_PULSE - 1)) state_next = RELEASE;
         end
         RELEASE: begin
            if (!i_irq_en) begin
               state_next = IDLE;
            end else if (rel_cnt_reg == RW'(RELEASE_MAX - 1)) begin
               rel_err    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg       <= IDLE;
         tmr_reg         <= '0;
         ack_cnt_reg     <= '0;
         rel_cnt_reg     <= '0;
         sel_q_reg       <= 8'd0;
         en_mask_reg     <= EN_MASK_INIT;
         ack_bit_reg     <= 1'b0;
         ack_src_reg     <= 8'd0;
         host_irq_reg    <= 1'b0;
         host_src_reg    <= 3'd0;
         busy_reg        <= 1'b0;
         svc_cnt_reg     <= 16'd0;
         timeout_cnt_reg <= 16'd0;
         err_reg         <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (accept)                      tmr_reg <= '0;
         else if (state_reg == WAIT_HOST) tmr_reg <= tmr_reg + TW'(1);

         ack_cnt_reg <= (state_reg == ACK)     ? ack_cnt_reg + AW'(1) : '0;
         rel_cnt_reg <= (state_reg == RELEASE) ? rel_cnt_reg + RW'(1) : '0;

         if (accept) begin
            sel_q_reg    <= i_irq_sel;
            host_src_reg <= sel_idx;
         end

         if (i_cfg_wr) en_mask_reg <= i_cfg_en;

         // Output flags follow the next state so they line up with it.
         host_irq_reg <= (state_next == WAIT_HOST);
         busy_reg     <= (state_next != IDLE);
         ack_bit_reg  <= (state_next == ACK);
         ack_src_reg  <= (state_next == ACK) ? sel_q_reg : 8'd0;

         if (svc_inc && svc_cnt_reg != 16'hFFFF)        svc_cnt_reg     <= svc_cnt_reg + 16'd1;
         if (to_inc && timeout_cnt_reg != 16'hFFFF)     timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
         if (bad_sel || rel_err)                        err_reg         <= 1'b1;
      end
   end

   assign o_host_irq    = host_irq_reg;
   assign o_host_src    = host_src_reg;
   assign o_irq_ack     = {15'd0, en_mask_reg, ack_bit_reg, ack_src_reg};
   assign o_busy        = busy_reg;
   assign o_svc_cnt     = svc_cnt_reg;
   assign o_timeout_cnt = timeout_cnt_reg;
   assign o_err         = err_reg;

endmodule

// File: doc/apb_irq_ack_ctrl.md
# apb_irq_ack_ctrl

Service sequencer on the consumer side of the APB interrupt arbiter. Takes the arbiter's one-hot source select and request, raises a level interrupt to the host with the encoded source, and waits for host service-done or a timeout. It then drives the arbiter's 32-bit acknowledge word so the pending source is cleared. The same word carries the per-source enable mask to the arbiter while no acknowledge is in flight.

## Interface
- `TIMEOUT_CYC`, 6_000_000 — host service timeout in `i_clk` cycles (100 ms at 60 MHz); must be ≥ 2.
- `ACK_PULSE`, 4 — cycles `o_irq_ack[8]` is held high per acknowledge; must be ≥ 3.
- `RELEASE_MAX`, 16 — maximum cycles to wait for `i_irq_en` to drop after an acknowledge.
- `EN_MASK_INIT`, 8'h07 — reset value of the enable mask.
- `i_clk` — in, 1 — single clock for all logic.
- `i_rst` — in, 1 — reset, asynchronous, active-high.
- `i_irq_sel` — in, 8 — one-hot source select from the arbiter.
- `i_irq_en` — in, 1 — arbiter request level.
- `i_cfg_wr` — in, 1 — single-cycle write strobe for the enable mask.
- `i_cfg_en` — in, 8 — new enable mask, sampled when `i_cfg_wr` = 1.
- `i_host_done` — in, 1 — host service-complete pulse.
- `o_host_irq` — out, 1 — interrupt level to the host.
- `o_host_src` — out, 3 — binary index of the serviced source.
- `o_irq_ack` — out, 32 — acknowledge/config word to the arbiter.
- `o_busy` — out, 1 — high whenever the state is not IDLE.
- `o_svc_cnt` — out, 16 — count of host-completed services, saturating.
- `o_timeout_cnt` — out, 16 — count of timed-out services, saturating.
- `o_err` — out, 1 — sticky error flag; cleared only by reset.

## Operation
- Acknowledge word layout: `o_irq_ack` = {15'd0, en_mask[7:0], ack_bit, ack_src[7:0]}.
  - `ack_bit` and `ack_src` are 0 except in ACK.
  - With [8:0] = 0, the arbiter reloads its enables from [16:9].
- `en_mask` is written from `i_cfg_en` on any cycle with `i_cfg_wr` = 1, in any state.
- The FSM has four states: IDLE, WAIT_HOST, ACK, RELEASE.
- IDLE:
  - Condition: `i_irq_en` = 1 and `i_irq_sel` is one-hot.
  - Action: latch `i_irq_sel` to `sel_q`, set `o_host_src` to its bit index, set `o_host_irq` = 1, clear the timeout counter, go to WAIT_HOST.
  - If `i_irq_en` = 1 and `i_irq_sel` is not one-hot: set `o_err` and stay in IDLE.
- WAIT_HOST:
  - On `i_host_done` = 1: increment `o_svc_cnt`, go to ACK.
  - Otherwise, when the counter reaches `TIMEOUT_CYC`-1: increment `o_timeout_cnt`, go to ACK.
  - Done and expiry in the same cycle count as done (`o_svc_cnt` only).
  - `o_host_irq` drops on entry to ACK.
- ACK:
  - Drive `ack_bit` = 1 and `ack_src` = `sel_q` for exactly `ACK_PULSE` cycles.
  - Then go to RELEASE.
- RELEASE:
  - Drive [8:0] = 0.
  - On `i_irq_en` = 0: go to IDLE.
  - If `i_irq_en` is still 1 after `RELEASE_MAX` cycles: set `o_err` and go to IDLE.
- `i_host_done` outside WAIT_HOST is ignored.
- Counters saturate at 16'hFFFF; they do not wrap.
- `o_host_src` holds its last value outside WAIT_HOST.

## Timing
- Reset values (asynchronous, immediate on `i_rst` = 1):
  - State = IDLE.
  - `o_host_irq` = 0, `o_host_src` = 0, `o_busy` = 0, `o_err` = 0.
  - Both counters = 0.
  - `en_mask` = `EN_MASK_INIT`, so `o_irq_ack` = {15'd0, `EN_MASK_INIT`, 9'd0}.
- Reset mid-service aborts the service: the host line drops and no acknowledge is issued.
- All outputs are registered.
- Request to host: `i_irq_en` sampled high at edge N → `o_host_irq` = 1 and `o_busy` = 1 after edge N.
- Done to acknowledge: `i_host_done` sampled at edge M → `o_irq_ack[8]` = 1 from M+1 through M+`ACK_PULSE`.
- `o_irq_ack[8:0]` returns to 0 after edge M+`ACK_PULSE`+1.
- Timeout: first WAIT_HOST cycle is counter 0; ACK is entered `TIMEOUT_CYC` cycles after WAIT_HOST entry.
- The arbiter detects the `ack_bit` rising edge through two register stages and drops `i_irq_en` about 3 cycles into ACK. Normal RELEASE therefore lasts 1 cycle.
- Minimum service, done in the first WAIT_HOST cycle: IDLE→IDLE takes 2 + `ACK_PULSE` cycles.
- A config write takes effect on `o_irq_ack[16:9]` the cycle after `i_cfg_wr`.

## Test plan
- **Basic service.** Reset; `i_irq_sel` = 8'h02 with `i_irq_en` = 1; `i_host_done` pulse 10 cycles later.
  - `o_host_src` = 1 and `o_host_irq` = 1 for 10 cycles.
  - `o_irq_ack` = 32'h0000_0F02 for 4 cycles; `o_svc_cnt` = 1.
- **Timeout.** `TIMEOUT_CYC` = 100; `i_irq_sel` = 8'h04 request with no done.
  - ACK starts exactly 100 cycles after WAIT_HOST entry with `o_irq_ack[8:0]` = 9'h104.
  - `o_timeout_cnt` = 1.
- **Simultaneous events.** `i_host_done` on the expiry cycle → `o_svc_cnt` increments and `o_timeout_cnt` is unchanged.
  - Separately, `i_cfg_wr` with 8'h05 during ACK → `o_irq_ack[16:9]` = 8'h05 next cycle while [8:0] is unchanged.
- **Error paths.**
  - `i_irq_sel` = 8'h03 with `i_irq_en` = 1 → stays IDLE and `o_err` = 1.
  - `i_irq_en` held high through RELEASE → `o_err` = 1 and IDLE after 16 cycles.
- **Reset mid-WAIT_HOST.** Assert `i_rst` mid-WAIT_HOST.
  - `o_host_irq` = 0 and `o_irq_ack` = 32'h0000_0E00 immediately.
  - A stray `i_host_done` afterwards causes no acknowledge.
